fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//  Write-side pointer and full-flag generator for the asynchronous FIFO, in the wclk domain.
//  Sits directly upstream of the FIFO memory and drives its winc/wfull/waddr write controls.
//  Keeps a binary + Gray write pointer and brings the read-domain Gray pointer into wclk.
//  Raises wfull pessimistically, so the memory is never overwritten.
// PARAMETERS
//  ADDRSIZE     4  memory address bits; DEPTH = 1<<ADDRSIZE; pointers are ADDRSIZE+1 bits
//  AFULL_THRESH 2  almost-full margin in entries (used only with FIFO_AFULL_EN); 1..DEPTH-1
// PORTS
//  wclk     in   1           write clock; the only clock
//  wrst_n   in   1           asynchronous active-low reset
//  winc     in   1           write request from producer
//  rptr     in   ADDRSIZE+1  read pointer, Gray coded, read-clock domain
//  waddr    out  ADDRSIZE    memory write address (= wbin[ADDRSIZE-1:0])
//  wptr     out  ADDRSIZE+1  registered Gray write pointer, to read-side sync
//  wfull    out  1           FIFO full, registered
//  wovf     out  1           one-cycle pulse: winc seen while wfull (write dropped)
//  wafull   out  1           almost full, registered (only with FIFO_AFULL_EN)
// BEHAVIOUR
//  - Reset (wrst_n low, async): wbin, wptr, both sync flops, wfull, wovf, wafull all 0.
//    waddr therefore 0. wrst_n deassertion is synchronised to wclk outside this block.
//  - wq2_rptr = rptr after 2 wclk flops. There is no other CDC path.
//  - wbinnext  = wbin + (winc & ~wfull), mod 2^(ADDRSIZE+1). Wraps silently.
//    wgraynext = (wbinnext>>1) ^ wbinnext.
//  - Each wclk edge: wbin<=wbinnext, wptr<=wgraynext.
//    The write takes effect at waddr on the same edge at which wbin advances.
//  - wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDRSIZE.
//    It asserts the edge that accepts the DEPTH-th unread write (zero extra latency).
//    It deasserts 3 wclk edges after rptr changes: 2 for sync, 1 for the register.
//  - wovf <= winc & wfull. Pointer and memory are unchanged on a dropped write.
//  - Simultaneous winc and read advance: the write is judged against the stale wq2_rptr.
//    The result may be a false full, never a missed full.
//  - Only wptr (Gray) leaves the domain. Exactly one bit changes per increment.
// CONFIGURATION
//  FIFO_AFULL_EN defined:
//    wcount = wbinnext - gray2bin(wq2_rptr) (mod 2^(A+1)).
//    wafull <= (wcount >= DEPTH - AFULL_THRESH). Reset 0.
//    wafull stays high whenever wfull is high.
//  FIFO_AFULL_EN undefined:
//    No gray2bin logic and no compare. wafull is tied 0.
// STRUCTURE
//  - fifo_pkg holds:
//    - FIFO_SYNC_STAGES = 2
//    - bin2gray / gray2bin functions (width-generic via a parameter-sized vector)
//    - shared by the read-side counterpart
//  - Sub-module sync_r2w: 2-flop synchroniser, width ADDRSIZE+1, async reset on wrst_n.
//  - The pointer, flag and optional almost-full logic live in fifo_wptr_full itself.
// TESTING (ADDRSIZE=2, AFULL_THRESH=1, FIFO_AFULL_EN on unless noted)
//  1. Fill: rptr=000, winc=1 for 4 clocks.
//     -> waddr 0,1,2,3; wptr 001,011,010,110.
//     -> wfull=1 after 4th edge; wafull=1 after 3rd edge.
//  2. Overflow: full, winc=1 for 2 clocks.
//     -> waddr stays 0, wptr stays 110, wovf=1 for 2 cycles then 0.
//  3. Drain latency: full, rptr 000->001.
//     -> wfull low after exactly the 3rd wclk edge; wafull stays 1.
//  4. Wrap: 9 writes, with rptr stepped to match wptr after each write.
//     -> wbin wraps 111->000; wfull never set; wptr Gray sequence single-bit steps.
//  5. Mid-op reset: wptr=110, wfull=1, pull wrst_n low between edges.
//     -> wptr, waddr, wfull, wafull = 0 immediately, with no clock edge.
//  6. FIFO_AFULL_EN undefined: repeat test 1.
//     -> wafull constant 0; wfull timing unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO constants and Gray-code helpers for the write and read pointer blocks.
package fifo_pkg;
  localparam int FIFO_SYNC_STAGES = 2;
  localparam int FIFO_PTR_MAX = 32;
  function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Callers zero-extend narrower pointers; leading zeros leave the low bits unaffected.
  function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] g);
    logic [FIFO_PTR_MAX-1:0] b;
    b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wptr_full_sync_r2w.sv
// sync_r2w: multi-flop synchroniser carrying the Gray read pointer into the write clock domain.
module sync_r2w
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] rptr_i,
  output logic [W-1:0] wq2_rptr_o
);
  logic [FIFO_SYNC_STAGES-1:0][W-1:0] sync_q;
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) sync_q <= '0;
    else sync_q <= {sync_q[FIFO_SYNC_STAGES-2:0], rptr_i};
  assign wq2_rptr_o = sync_q[FIFO_SYNC_STAGES-1];
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: async-FIFO write pointer, pessimistic full flag and overflow pulse in the wclk domain.
// Define FIFO_AFULL_EN to build the registered almost-full flag; otherwise wafull is tied low.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wovf,
  output logic                wafull
);
  localparam int PW = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  logic [ADDRSIZE:0] wq2_rptr, wbin_q, wbin_d, wptr_q, wptr_d;
  logic wfull_q, wfull_d, wovf_q, wovf_d;
  sync_r2w #(.W(PW)) u_sync (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .rptr_i    (rptr),
    .wq2_rptr_o(wq2_rptr)
  );
  // Full when the next Gray pointer is a whole lap ahead of the (stale) synced read pointer.
  always_comb begin
    wbin_d  = wbin_q + PW'(winc & ~wfull_q);
    wptr_d  = PW'(bin2gray(FIFO_PTR_MAX'(wbin_d)));
    wfull_d = wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wovf_d  = winc & wfull_q;
  end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      wovf_q  <= wovf_d;
    end
`ifdef FIFO_AFULL_EN
  logic [ADDRSIZE:0] wcount;
  logic wafull_q, wafull_d;
  always_comb begin
    wcount   = wbin_d - PW'(gray2bin(FIFO_PTR_MAX'(wq2_rptr)));
    wafull_d = wcount >= PW'(DEPTH - AFULL_THRESH);
  end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) wafull_q <= 1'b0;
    else wafull_q <= wafull_d;
  assign wafull = wafull_q;
`else
  assign wafull = 1'b0;
`endif
  assign waddr = wbin_q[ADDRSIZE-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign wovf  = wovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed checks of fill, overflow, drain latency, wrap and async reset (ADDRSIZE=2).
module tb_fifo_wptr_full;
  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [2:0] rptr = 3'b000;
  logic [1:0] waddr;
  logic [2:0] wptr;
  logic       wfull, wovf, wafull;
`ifdef FIFO_AFULL_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif
  int nvec = 0;
  int nerr = 0;
  logic [2:0] fill_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};

  fifo_wptr_full #(.ADDRSIZE(2), .AFULL_THRESH(1)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .winc  (winc),
    .rptr  (rptr),
    .waddr (waddr),
    .wptr  (wptr),
    .wfull (wfull),
    .wovf  (wovf),
    .wafull(wafull)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [2:0] b, g, prev;
    #12;
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_wovf", 32'(wovf), 0);
    chk("rst_wafull", 32'(wafull), 0);
    wrst_n = 1'b1;
    @(negedge wclk);
    winc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      tick();
      chk("fill_wptr", 32'(wptr), 32'(fill_gray[i]));
      chk("fill_wfull", 32'(wfull), 32'(i == 3));
      chk("fill_wafull", 32'(wafull), 32'(AF && i >= 2));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ovf_wovf", 32'(wovf), 1);
      chk("ovf_wptr", 32'(wptr), 32'b110);
      chk("ovf_waddr", 32'(waddr), 0);
      chk("ovf_wfull", 32'(wfull), 1);
    end
    winc = 1'b0;
    tick();
    chk("ovf_end_wovf", 32'(wovf), 0);
    chk("ovf_end_wptr", 32'(wptr), 32'b110);
    #2 wrst_n = 1'b0;
    #1;
    chk("mrst_wptr", 32'(wptr), 0);
    chk("mrst_waddr", 32'(waddr), 0);
    chk("mrst_wfull", 32'(wfull), 0);
    chk("mrst_wafull", 32'(wafull), 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    winc = 1'b1;
    repeat (4) tick();
    winc = 1'b0;
    chk("refill_wfull", 32'(wfull), 1);
    chk("refill_wptr", 32'(wptr), 32'b110);
    rptr = 3'b001;
    tick();
    chk("drain_e1_wfull", 32'(wfull), 1);
    tick();
    chk("drain_e2_wfull", 32'(wfull), 1);
    tick();
    chk("drain_e3_wfull", 32'(wfull), 0);
    chk("drain_wafull", 32'(wafull), 32'(AF));
    rptr = 3'b110;
    repeat (3) tick();
    chk("empty_wfull", 32'(wfull), 0);
    chk("empty_wafull", 32'(wafull), 0);
    b = 3'd4;
    prev = 3'b110;
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      chk("wrap_waddr", 32'(waddr), 32'(b[1:0]));
      tick();
      winc = 1'b0;
      b = b + 3'd1;
      g = b ^ (b >> 1);
      chk("wrap_wptr", 32'(wptr), 32'(g));
      chk("wrap_onebit", 32'($countones(wptr ^ prev)), 1);
      chk("wrap_wfull", 32'(wfull), 0);
      chk("wrap_wafull", 32'(wafull), 0);
      prev = g;
      rptr = g;
      repeat (3) tick();
    end
    chk("wrap_final_waddr", 32'(waddr), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
